// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : PS/2 scan-code to ASCII/control decoder with make/break, extended
//            prefix, Shift, typematic-repeat suppression and an output FIFO.
//            Optional Caps Lock support is enabled by defining CAPSLOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_AW         = 3,
    parameter int REPEAT_SUPPRESS = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] scan_data,
    input  logic       scan_valid,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_rd,
    output logic       overflow,
    output logic       caps_on
);

    localparam logic [7:0] c_brk_code  = 8'hF0;
    localparam logic [7:0] c_ext_code  = 8'hE0;
    localparam logic [7:0] c_lshift    = 8'h12;
    localparam logic [7:0] c_rshift    = 8'h59;
    localparam logic [7:0] c_enter     = 8'h5A;
    localparam logic [7:0] c_caps_code = 8'h58;
    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t r_state;
    logic       r_shift;
    logic       r_caps;
    logic [7:0] r_last_make;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    logic       w_is_make;
    logic       w_accept;
    logic       w_push;
    logic [7:0] w_map;
    logic [7:0] w_push_data;
    logic       w_is_letter;
    logic       w_full;
    logic       w_rd;
    logic       w_wr;

    function automatic logic [7:0] f_map(input logic [7:0] code);
        logic [7:0] v;
        v = 8'h00;
        case (code)
            8'h1C: v = "a";  8'h32: v = "b";  8'h21: v = "c";  8'h23: v = "d";
            8'h24: v = "e";  8'h2B: v = "f";  8'h34: v = "g";  8'h33: v = "h";
            8'h43: v = "i";  8'h3B: v = "j";  8'h42: v = "k";  8'h4B: v = "l";
            8'h3A: v = "m";  8'h31: v = "n";  8'h44: v = "o";  8'h4D: v = "p";
            8'h15: v = "q";  8'h2D: v = "r";  8'h1B: v = "s";  8'h2C: v = "t";
            8'h3C: v = "u";  8'h2A: v = "v";  8'h1D: v = "w";  8'h22: v = "x";
            8'h35: v = "y";  8'h1A: v = "z";
            8'h45: v = "0";  8'h16: v = "1";  8'h1E: v = "2";  8'h26: v = "3";
            8'h25: v = "4";  8'h2E: v = "5";  8'h36: v = "6";  8'h3D: v = "7";
            8'h3E: v = "8";  8'h46: v = "9";
            8'h70: v = "0";  8'h69: v = "1";  8'h72: v = "2";  8'h7A: v = "3";
            8'h6B: v = "4";  8'h73: v = "5";  8'h74: v = "6";  8'h6C: v = "7";
            8'h75: v = "8";  8'h7D: v = "9";
            8'h4C: v = ":";  8'h55: v = "=";
            8'h29: v = 8'h01;
            8'h5A: v = 8'h02;
            8'h66: v = 8'h03;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Decode of the byte arriving this cycle; pushes land at this edge.
    always_comb begin
        w_is_make   = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_map       = f_map(scan_data);
        w_is_letter = (w_map >= 8'h61) && (w_map <= 8'h7A);
        w_push_data = (w_is_letter && (r_shift ^ r_caps)) ? (w_map - 8'h20) : w_map;
        if (scan_valid) begin
            case (r_state)
                S_IDLE: begin
                    if ((scan_data != c_brk_code) && (scan_data != c_ext_code) &&
                        (scan_data != c_lshift) && (scan_data != c_rshift)) begin
                        w_is_make = 1'b1;
                        w_accept  = !((REPEAT_SUPPRESS != 0) && (scan_data == r_last_make));
                        w_push    = w_accept && (w_map != 8'h00);
                    end
                end
                S_EXT: begin
                    if (scan_data == c_enter) begin
                        w_push      = 1'b1;
                        w_push_data = 8'h02;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_shift     <= 1'b0;
            r_caps      <= 1'b0;
            r_last_make <= 8'h00;
        end else if (scan_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (scan_data == c_brk_code)
                        r_state <= S_BRK;
                    else if (scan_data == c_ext_code)
                        r_state <= S_EXT;
                    else if ((scan_data == c_lshift) || (scan_data == c_rshift))
                        r_shift <= 1'b1;
                    else if (w_is_make && w_accept) begin
                        r_last_make <= scan_data;
`ifdef CAPSLOCK_EN
                        if (scan_data == c_caps_code)
                            r_caps <= ~r_caps;
`endif
                    end
                end
                S_BRK: begin
                    r_state <= S_IDLE;
                    if ((scan_data == c_lshift) || (scan_data == c_rshift))
                        r_shift <= 1'b0;
                    if (scan_data == r_last_make)
                        r_last_make <= 8'h00;
                end
                S_EXT: begin
                    r_state <= (scan_data == c_brk_code) ? S_EXT_BRK : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop while full frees the slot the simultaneous push needs.
    assign w_full = (r_count == c_depth);
    assign w_rd   = ascii_rd && (r_count != '0);
    assign w_wr   = w_push && (!w_full || w_rd);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_rd)
                r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr)
                r_count <= r_count - 1'b1;
            if (w_push && !w_wr)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    assign ascii_valid = (r_count != '0);
    assign ascii_out   = ascii_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign overflow    = r_overflow;
`ifdef CAPSLOCK_EN
    assign caps_on     = r_caps;
`else
    assign caps_on     = 1'b0;
`endif

endmodule

`default_nettype wire
